// File: rtl/slice_addsub_seq.sv
`default_nettype none
//==============================================================================
// Module   : slice_addsub_seq
// Purpose  : Multi-precision adder/subtractor. Operands are latched on an
//            accepted start and pushed LSB-first through one 4-bit
//            ripple-carry add/sub slice per clock. The slice carry is chained
//            between cycles in a register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters:
//   SLICES  number of 4-bit slices (1..16)
//   WIDTH   operand/result width, fixed at 4*SLICES
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   start   operation request, sampled only while not busy
//   op_sub  0 = a+b, 1 = a-b (latched with start)
//   a, b    WIDTH-bit operands (latched with start)
//   busy    high while slices are being processed
//   done    one-cycle pulse: result and flags are valid
//   result  sum/difference, held until the next accepted start
//   cout    carry out of the top slice (subtract: 1 = no borrow)
//   ovf     two's-complement overflow
//   zero    result == 0 (only when ZERO_FLAG_EN is defined)
// Build option:
//   ZERO_FLAG_EN  adds the zero output and its sticky tracking logic
//==============================================================================
module slice_addsub_seq #(
  parameter int  SLICES = 4,
  localparam int WIDTH  = 4 * SLICES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_LAST_K = 4'(SLICES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_carry;
  logic [3:0]       r_k;
`ifdef ZERO_FLAG_EN
  logic             r_allzero;
`endif

  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_a_sl;
  logic [3:0]       w_b_eff;
  logic [4:0]       w_sum;

  // start is honoured in IDLE and in the DONE cycle (back-to-back issue).
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_k == C_LAST_K);

  // Current slice; subtraction is a + ~b + 1, the +1 entering via the
  // carry register, which is preloaded with op_sub.
  assign w_a_sl   = r_a[4*r_k +: 4];
  assign w_b_eff  = r_b[4*r_k +: 4] ^ {4{r_sub}};
  assign w_sum    = {1'b0, w_a_sl} + {1'b0, w_b_eff} + {4'd0, r_carry};

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand latches, slice sequencing and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_k     <= 4'd0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
`ifdef ZERO_FLAG_EN
      zero      <= 1'b0;
      r_allzero <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sub   <= op_sub;
      r_carry <= op_sub;
      r_k     <= 4'd0;
`ifdef ZERO_FLAG_EN
      r_allzero <= 1'b1;
`endif
    end else if (r_state == RUN) begin
      result[4*r_k +: 4] <= w_sum[3:0];
      r_carry            <= w_sum[4];
      r_k                <= r_k + 4'd1;
`ifdef ZERO_FLAG_EN
      r_allzero <= r_allzero & (w_sum[3:0] == 4'd0);
`endif
      if (w_last) begin
        cout <= w_sum[4];
        // Overflow: operands of equal sign produce a result of the other sign.
        ovf  <= (w_a_sl[3] == w_b_eff[3]) && (w_sum[3] != w_a_sl[3]);
`ifdef ZERO_FLAG_EN
        zero <= r_allzero & (w_sum[3:0] == 4'd0);
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slice_addsub_seq.sv
`default_nettype none
//==============================================================================
// Module   : tb_slice_addsub_seq
// Purpose  : Self-checking bench for slice_addsub_seq (SLICES=4, WIDTH=16).
//            Directed vector table, handshake/reset sequences and random
//            operations compared against a full-width arithmetic model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_slice_addsub_seq;

  localparam int SLICES = 4;
  localparam int W      = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
`ifdef ZERO_FLAG_EN
  logic         zero;
`endif

  int vectors     = 0;
  int miscompares = 0;

  slice_addsub_seq #(.SLICES(SLICES)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
`ifdef ZERO_FLAG_EN
    .zero   (zero),
`endif
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic modulo 2^W.
  task automatic model(input logic op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic c, output logic v,
                       output logic z);
    logic [W:0] full;
    if (!op) begin
      full = {1'b0, x} + {1'b0, y};
      r    = full[W-1:0];
      c    = full[W];
      v    = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r = x - y;
      c = (x >= y);
      v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    z = (r == '0);
  endtask

  // Drive a request and return #1 after the accepting edge.
  task automatic issue(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
    start  = 1'b1;
    op_sub = op;
    a      = x;
    b      = y;
    @(posedge clk); #1;
    start  = 1'b0;
    op_sub = 1'($urandom);
    a      = W'($urandom);
    b      = W'($urandom);
  endtask

  // Count edges until done; also count cycles with busy high on the way.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    do begin
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
    end while (!done && n < 20);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] r, input logic c,
                              input logic v, input logic z);
    chk({tag, " done"},   32'(done),   32'd1);
    chk({tag, " busy@d"}, 32'(busy),   32'd0);
    chk({tag, " result"}, 32'(result), 32'(r));
    chk({tag, " cout"},   32'(cout),   32'(c));
    chk({tag, " ovf"},    32'(ovf),    32'(v));
`ifdef ZERO_FLAG_EN
    chk({tag, " zero"},   32'(zero),   32'(z));
`else
    if (z) begin end
`endif
  endtask

  task automatic run_op(input string tag, input logic op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] r, input logic c,
                        input logic v, input logic z);
    int n, nb;
    issue(op, x, y);
    wait_done(n, nb);
    chk({tag, " latency"}, 32'(n), 32'(SLICES));
    chk({tag, " busycyc"}, 32'(nb), 32'(SLICES));
    check_result(tag, r, c, v, z);
    @(posedge clk); #1;
    chk({tag, " pulse"}, 32'(done), 32'd0);
    chk({tag, " hold"},  32'(result), 32'(r));
  endtask

  vec_t tbl[7];

  initial begin
    logic [W-1:0] r, x, y;
    logic c, v, z, op;
    int n, nb, ndone;

    tbl[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy",   32'(busy),   32'd0);
    chk("rst done",   32'(done),   32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst cout",   32'(cout),   32'd0);
    chk("rst ovf",    32'(ovf),    32'd0);
`ifdef ZERO_FLAG_EN
    chk("rst zero",   32'(zero),   32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].res, tbl[i].c, tbl[i].v, tbl[i].z);

    // start during RUN is ignored
    issue(1'b0, 16'h1111, 16'h2222);
    start = 1'b1; op_sub = 1'b1; a = 16'hAAAA; b = 16'h5555;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, nb);
    chk("ign latency", 32'(n), 32'(SLICES - 1));
    check_result("ign", 16'h3333, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start in the DONE cycle
    issue(1'b0, 16'h0100, 16'h0200);
    wait_done(n, nb);
    check_result("b2b1", 16'h0300, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 16'h0300, 16'h0400);
    wait_done(n, nb);
    chk("b2b2 latency", 32'(n), 32'(SLICES));
    check_result("b2b2", 16'hFF00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset on the 2nd RUN edge
    issue(1'b0, 16'h7FFF, 16'h7FFF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst busy",   32'(busy),   32'd0);
    chk("mrst result", 32'(result), 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("mrst nodone", 32'(ndone), 32'd0);
    run_op("post", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      op = 1'($urandom);
      x  = W'($urandom);
      y  = (i % 8 == 0) ? x : W'($urandom);
      model(op, x, y, r, c, v, z);
      run_op($sformatf("rnd%0d", i), op, x, y, r, c, v, z);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
